// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for four requesters that steers the winner's data bit onto data_out.
// An owner keeps the grant for at most MAX_HOLD consecutive cycles before it is rearbitrated.
module rr_mux_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] data_in,
  output logic [3:0] grant,
  output logic [1:0] select_lines,
  output logic       data_out,
  output logic       valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] sel_d;
  logic [3:0] grant_d;
  logic       valid_d;
  logic [2:0] pick_idle, pick_rearb;

  // Returns {found, index} of the first request after base, wrapping round to base itself last.
  function automatic logic [2:0] rr_pick(input logic [1:0] base, input logic [3:0] r);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [3:0] one_hot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  assign pick_idle  = rr_pick(last_q, req);
  assign pick_rearb = rr_pick(select_lines, req);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    sel_d   = select_lines;
    grant_d = grant;
    valid_d = valid;
    case (state_q)
      IDLE: begin
        if (pick_idle[2]) begin
          state_d = GRANT;
          sel_d   = pick_idle[1:0];
          cnt_d   = 4'd1;
          grant_d = one_hot(pick_idle[1:0]);
          valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (req[select_lines] && (cnt_q < HOLD_LIMIT)) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          // Owner released or used up its slot: hand over in the same edge, or fall idle.
          last_d = select_lines;
          if (pick_rearb[2]) begin
            sel_d   = pick_rearb[1:0];
            cnt_d   = 4'd1;
            grant_d = one_hot(pick_rearb[1:0]);
          end else begin
            state_d = IDLE;
            grant_d = 4'b0000;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= 2'd3;
      cnt_q        <= 4'd0;
      select_lines <= 2'd0;
      grant        <= 4'b0000;
      valid        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      select_lines <= sel_d;
      grant        <= grant_d;
      valid        <= valid_d;
    end
  end

  assign data_out = valid & data_in[select_lines];

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios with literal expectations plus a
// behavioural ownership model compared on every falling edge and a starvation watchdog.
module tb_rr_mux_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int STARVE_BOUND = 3 * MAX_HOLD + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] data_in = 4'b0000;
  logic [3:0] grant;
  logic [1:0] select_lines;
  logic       data_out;
  logic       valid;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  // Model state: who owns the mux, for how long, and who was served last.
  bit m_valid = 1'b0;
  int m_sel = 0;
  int m_last = 3;
  int m_tenure = 0;
  int wait_cnt [4] = '{0, 0, 0, 0};

  rr_mux_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .data_in(data_in),
    .grant(grant),
    .select_lines(select_lines),
    .data_out(data_out),
    .valid(valid)
  );

  always #5 clk = ~clk;

  function automatic int next_owner(input int base, input logic [3:0] r);
    for (int off = 1; off <= 4; off++) begin
      if (r[(base + off) % 4]) return (base + off) % 4;
    end
    return -1;
  endfunction

  // Ownership model advanced on each rising edge from the requests seen there.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 1'b0;
      m_sel = 0;
      m_last = 3;
      m_tenure = 0;
    end else if (!m_valid) begin
      if (next_owner(m_last, req) >= 0) begin
        m_sel = next_owner(m_last, req);
        m_valid = 1'b1;
        m_tenure = 1;
      end
    end else if (req[m_sel] && m_tenure < MAX_HOLD) begin
      m_tenure++;
    end else begin
      m_last = m_sel;
      if (next_owner(m_sel, req) >= 0) begin
        m_sel = next_owner(m_sel, req);
        m_tenure = 1;
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] exp_grant;
    logic       exp_dout;
    if (checking) begin
      exp_grant = m_valid ? 4'(1 << m_sel) : 4'b0000;
      exp_dout  = m_valid ? data_in[m_sel] : 1'b0;
      checks++;
      if (grant !== exp_grant || select_lines !== 2'(m_sel) || valid !== m_valid || data_out !== exp_dout) begin
        errors++;
        $display("[TB] FAIL model_cmp t=%0t grant=%b want %b sel=%0d want %0d valid=%b want %b dout=%b want %b",
                 $time, grant, exp_grant, select_lines, m_sel, valid, m_valid, data_out, exp_dout);
      end
      for (int i = 0; i < 4; i++) begin
        if (req[i] && !grant[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        checks++;
        if (wait_cnt[i] > STARVE_BOUND) begin
          errors++;
          $display("[TB] FAIL starvation req%0d waited=%0d limit %0d", i, wait_cnt[i], STARVE_BOUND);
          wait_cnt[i] = 0;
        end
      end
    end else begin
      for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    end
  end

  // Drive inputs just after a rising edge, then move to just after the edge that samples them.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d);
    req = r;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eg, input logic [1:0] es,
                             input logic ev, input logic ed);
    checks++;
    if (grant !== eg || select_lines !== es || valid !== ev || data_out !== ed) begin
      errors++;
      $display("[TB] FAIL %s t=%0t grant=%b want %b sel=%0d want %0d valid=%b want %b dout=%b want %b",
               name, $time, grant, eg, select_lines, es, valid, ev, data_out, ed);
    end
  endtask

  initial begin
    int exp_sel_a [17];
    logic exp_dout_a [4];
    exp_sel_a = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};
    exp_dout_a = '{1'b0, 1'b1, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    checking = 1'b1;

    // Full contention rotates in blocks of MAX_HOLD cycles without gaps.
    for (int k = 0; k < 17; k++) begin
      applyStimulus(4'b1111, 4'b1010);
      checkOutput("rr_rotation", 4'(1 << exp_sel_a[k]), 2'(exp_sel_a[k]), 1'b1, exp_dout_a[exp_sel_a[k]]);
    end

    applyStimulus(4'b0000, 4'b0000);
    checkOutput("release_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 4'b0000);
    checkOutput("grant_owner2", 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("idle_keeps_sel", 4'b0000, 2'd2, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b0100);
    checkOutput("idle_stays", 4'b0000, 2'd2, 1'b0, 1'b0);
    applyStimulus(4'b0100, 4'b0100);
    checkOutput("regrant_owner2", 4'b0100, 2'd2, 1'b1, 1'b1);

    applyStimulus(4'b1000, 4'b0000);
    checkOutput("handover_3", 4'b1000, 2'd3, 1'b1, 1'b0);
    applyStimulus(4'b1001, 4'b0000);
    checkOutput("no_preempt", 4'b1000, 2'd3, 1'b1, 1'b0);
    applyStimulus(4'b0001, 4'b0000);
    checkOutput("no_bubble", 4'b0001, 2'd0, 1'b1, 1'b0);

    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0011, 4'b0010);
      checkOutput("hold_owner0", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    applyStimulus(4'b0011, 4'b0010);
    checkOutput("hold_handover", 4'b0010, 2'd1, 1'b1, 1'b1);

    for (int k = 0; k < 11; k++) begin
      applyStimulus(4'b1000, 4'b1000);
      checkOutput("sole_regrant", 4'b1000, 2'd3, 1'b1, 1'b1);
    end

    applyStimulus(4'b0010, 4'b0010);
    checkOutput("grant_owner1", 4'b0010, 2'd1, 1'b1, 1'b1);
    applyStimulus(4'b0010, 4'b0010);
    checkOutput("owner1_cnt2", 4'b0010, 2'd1, 1'b1, 1'b1);
    #1 reset = 1'b1;
    #1 checkOutput("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset", 4'b0010, 2'd1, 1'b1, 1'b1);

    applyStimulus(4'b0000, 4'b0000);
    checkOutput("final_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'b1111);
    checkOutput("final_idle_hold", 4'b0000, 2'd1, 1'b0, 1'b0);

    @(negedge clk);
    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL have parameter: MAX_HOLD, 4, maximum consecutive cycles one requester keeps the grant (legal 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: req  input  4  request line per requester 0..3.
REQ-005 SHALL have port: data_in  input  4  1-bit data per requester; bit i belongs to requester i.
REQ-006 SHALL have port: grant  output  4  one-hot grant, registered.
REQ-007 SHALL have port: select_lines  output  2  binary index of the granted requester, registered.
REQ-008 SHALL have port: data_out  output  1  data_in[select_lines] while valid, else 0, combinational from registered select.
REQ-009 SHALL have port: valid  output  1  high while a grant is active, registered.

Function
REQ-010 SHALL implement two states: IDLE (no grant) and GRANT (one requester owns the mux).
REQ-011 SHALL keep internal state: last-served pointer (2 bits) and hold counter (4 bits).
REQ-012 In IDLE with req == 0, SHALL remain in IDLE; outputs unchanged (grant=0, valid=0).
REQ-013 In IDLE with req != 0, SHALL at the next edge grant the first requesting index in order last+1, last+2, last+3, last (mod 4); enter GRANT; hold counter := 1.
REQ-014 Grant latency SHALL be exactly one cycle: req sampled at edge N, grant/valid/select_lines visible after edge N.
REQ-015 In GRANT, SHALL keep the grant unchanged while req[select_lines]=1 and hold counter < MAX_HOLD; counter increments by 1 each such edge.
REQ-016 In GRANT, a rearbitration event SHALL occur at an edge where req[select_lines]=0 or hold counter == MAX_HOLD.
REQ-017 On rearbitration, SHALL search order sel+1, sel+2, sel+3, sel (mod 4) over current req; first set bit wins in the same edge (no idle bubble); counter := 1; last := previous sel.
REQ-018 On rearbitration with no eligible request, SHALL go to IDLE with grant=0, valid=0; select_lines and last keep the last served index.
REQ-019 A sole requester hitting MAX_HOLD SHALL be re-granted immediately (counter restarts at 1, grant stays high without a gap).
REQ-020 grant SHALL always equal the one-hot decode of select_lines when valid=1, and 4'b0000 when valid=0.
REQ-021 A newly asserted request on a non-granted line SHALL NOT preempt the current owner before a rearbitration event.
REQ-022 Any requester continuously requesting SHALL be granted within 3*MAX_HOLD+1 cycles (starvation bound).
REQ-023 data_out SHALL follow data_in[select_lines] within the same cycle while valid=1.

Reset
REQ-024 On reset=1, SHALL asynchronously force state=IDLE, grant=0, select_lines=0, valid=0, data_out=0, hold counter=0, last=3 (requester 0 has first priority).
REQ-025 Reset asserted mid-grant SHALL drop grant and valid immediately without waiting for a clock edge.
REQ-026 After reset deasserts, first arbitration SHALL occur at the first rising edge with reset=0 and req!=0.

Verification
REQ-027 After reset, req=4'b1111 held, MAX_HOLD=4 -> grant sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001..., select_lines 0,1,2,3, no gaps in valid.
REQ-028 Owner 2 granted, req drops to 4'b0000 -> next edge grant=0000, valid=0, select_lines=2; later req=4'b0100 -> grant=0100 one cycle later.
REQ-029 Only req=4'b1000 held for 10 cycles -> grant=1000 and valid=1 continuously, counter wraps 1..4 without a bubble.
REQ-030 Owner 0 granted, req changes 4'b0001 -> 4'b0011 -> grant stays 0001 until counter=4, then 0010; with data_in=4'b0010, data_out goes 0 -> 1 at the handover.
REQ-031 Owner 1 granted with counter=2, reset pulsed between edges -> grant=0000, valid=0, data_out=0 immediately; after release with req=4'b0010 -> grant=0010 at next edge.
REQ-032 Owner 3 releases (req 4'b1001 -> 4'b0001) -> grant=0001 at the same edge, no IDLE cycle.
